vadd_axis_packet_arbiter: RTL and testbench



---
 rtl/vadd_arb_pkg.sv | 14 +
 rtl/vadd_rr_picker.sv | 37 +++
 rtl/vadd_axis_packet_arbiter.sv | 102 ++++++++++
 tb/tb_vadd_axis_packet_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vadd_arb_pkg.sv
// Shared types and helpers for the vector-add stream arbiter.
package vadd_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vadd_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts just after the previous winner, then priority-encode from the bottom.
module vadd_rr_picker #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_grant_i,
    output logic [NumReq-1:0] win_oh_o,
    output logic [IdxW-1:0]   win_idx_o
);

    logic [2*NumReq-1:0] req_dbl;
    logic [NumReq-1:0]   req_rot;
    logic                found;
    int unsigned         start;
    int unsigned         offset;
    int unsigned         win;

    always_comb begin
        start   = (32'(last_grant_i) + 32'd1) % NumReq;
        req_dbl = {req_i, req_i};
        req_rot = NumReq'(req_dbl >> start);
        found   = 1'b0;
        offset  = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        win       = (start + offset) % NumReq;
        win_idx_o = IdxW'(win);
        win_oh_o  = found ? (NumReq'(1) << win) : '0;
    end

endmodule

// File: rtl/vadd_axis_packet_arbiter.sv
// Packet-locked round-robin AXI4-Stream arbiter in front of the vector adder;
// the winner's index travels on m_axis_tdest so results can be routed back.
module vadd_axis_packet_arbiter
    import vadd_arb_pkg::*;
#(
    parameter int unsigned C_NUM_REQ            = 4,
    parameter int unsigned C_AXIS_TDATA_WIDTH   = 512,
    parameter int unsigned C_M_AXIS_TDEST_WIDTH = 4
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    input  logic                                      enable,
    input  logic [C_NUM_REQ-1:0]                      s_axis_tvalid,
    output logic [C_NUM_REQ-1:0]                      s_axis_tready,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_NUM_REQ-1:0]                      s_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [C_M_AXIS_TDEST_WIDTH-1:0]           m_axis_tdest,
    output logic                                      busy,
    output logic                                      pkt_done,
    output logic [C_M_AXIS_TDEST_WIDTH-1:0]           pkt_done_id
);

    localparam int unsigned IdxW  = idx_width(C_NUM_REQ);
    localparam int unsigned KeepW = C_AXIS_TDATA_WIDTH / 8;

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     grant_id_q, grant_id_d;
    logic [IdxW-1:0]     last_grant_q, last_grant_d;
    logic [C_NUM_REQ-1:0] win_oh;
    logic [IdxW-1:0]     win_idx;
    int unsigned         sel;

    vadd_rr_picker #(
        .NumReq (C_NUM_REQ),
        .IdxW   (IdxW)
    ) u_picker (
        .req_i        (s_axis_tvalid),
        .last_grant_i (last_grant_q),
        .win_oh_o     (win_oh),
        .win_idx_o    (win_idx)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_grant_q <= IdxW'(C_NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        sel           = 32'(grant_id_q);
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;
        busy          = 1'b0;
        pkt_done      = 1'b0;
        pkt_done_id   = '0;
        unique case (state_q)
            StIdle: begin
                if (enable && |win_oh) begin
                    state_d      = StXfer;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                end
            end
            StXfer: begin
                busy               = 1'b1;
                m_axis_tvalid      = s_axis_tvalid[grant_id_q];
                m_axis_tdata       = C_AXIS_TDATA_WIDTH'(s_axis_tdata >> (sel * C_AXIS_TDATA_WIDTH));
                m_axis_tkeep       = KeepW'(s_axis_tkeep >> (sel * KeepW));
                m_axis_tlast       = s_axis_tlast[grant_id_q];
                m_axis_tdest       = C_M_AXIS_TDEST_WIDTH'(grant_id_q);
                s_axis_tready[grant_id_q] = m_axis_tready;
                // Grant is held through stalls until the tlast handshake.
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d     = StIdle;
                    pkt_done    = 1'b1;
                    pkt_done_id = C_M_AXIS_TDEST_WIDTH'(grant_id_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_vadd_axis_packet_arbiter.sv
// Scoreboard bench for the packet arbiter: per-requester source queues feed the
// DUT, expected M beats are queued at load time and compared on each handshake.
module tb_vadd_axis_packet_arbiter;

    localparam int NUM = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int TW  = 4;

    typedef struct packed {
        logic [TW-1:0] dest;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic                aclk = 1'b0;
    logic                areset;
    logic                enable;
    logic [NUM-1:0]      s_axis_tvalid;
    logic [NUM-1:0]      s_axis_tready;
    logic [NUM*DW-1:0]   s_axis_tdata;
    logic [NUM*KW-1:0]   s_axis_tkeep;
    logic [NUM-1:0]      s_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic [KW-1:0]       m_axis_tkeep;
    logic                m_axis_tlast;
    logic [TW-1:0]       m_axis_tdest;
    logic                busy;
    logic                pkt_done;
    logic [TW-1:0]       pkt_done_id;

    beat_t          src_q [NUM][$];
    beat_t          exp_q [$];
    int             beat_cyc [$];
    logic [NUM-1:0] fired;
    logic           tog;
    int             cyc;
    int             first_req_cyc;
    int             n_cmp;
    int             n_err;

    always #5 aclk = ~aclk;

    vadd_axis_packet_arbiter #(
        .C_NUM_REQ            (NUM),
        .C_AXIS_TDATA_WIDTH   (DW),
        .C_M_AXIS_TDEST_WIDTH (TW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .pkt_done_id   (pkt_done_id)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*DW +: DW]  = src_q[i][0].data;
                s_axis_tkeep[i*KW +: KW]  = src_q[i][0].keep;
                s_axis_tlast[i]           = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW]  = '0;
                s_axis_tkeep[i*KW +: KW]  = '0;
                s_axis_tlast[i]           = 1'b0;
            end
        end
    endtask

    // Sampled on the falling edge, clear of the active edge.
    task automatic monitor();
        logic [NUM-1:0] exp_r;
        beat_t          e;
        fired = '0;
        if (areset) return;
        cyc++;
        if (first_req_cyc < 0 && |s_axis_tvalid) first_req_cyc = cyc;
        if (!busy) begin
            check_eq("idle_sready", 64'(s_axis_tready), 64'd0);
            check_eq("idle_mvalid", 64'(m_axis_tvalid), 64'd0);
        end else begin
            exp_r = '0;
            exp_r[m_axis_tdest[1:0]] = m_axis_tready;
            check_eq("sready_mirror", 64'(s_axis_tready), 64'(exp_r));
        end
        fired = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_cyc.push_back(cyc);
            check_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("tdest", 64'(m_axis_tdest), 64'(e.dest));
                check_eq("tdata", 64'(m_axis_tdata), 64'(e.data));
                check_eq("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                check_eq("tlast", 64'(m_axis_tlast), 64'(e.last));
                check_eq("pkt_done", 64'(pkt_done), 64'(e.last));
                if (e.last) check_eq("pkt_done_id", 64'(pkt_done_id), 64'(e.dest));
            end
        end else begin
            check_eq("pkt_done_quiet", 64'(pkt_done), 64'd0);
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (tog) m_axis_tready = ~m_axis_tready;
        drive();
    endtask

    task automatic load_pkt(input int id, input int pkt, input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.dest = TW'(id);
            e.data = {4'hA, 4'(id), 8'(pkt), 8'(b), 8'h3C};
            e.keep = KW'(4'hC ^ 4'(b));
            e.last = (b == n - 1);
            src_q[id].push_back(e);
            exp_q.push_back(e);
        end
        drive();
    endtask

    task automatic clear_marks();
        first_req_cyc = -1;
        beat_cyc.delete();
    endtask

    task automatic flush();
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        exp_q.delete();
        drive();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        flush();
        cycle();
        cycle();
        check_eq("rst_sready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(pkt_done), 64'd0);
        check_eq("rst_mdata", 64'(m_axis_tdata), 64'd0);
        check_eq("rst_mside", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tdest, pkt_done_id}), 64'd0);
        areset = 1'b0;
        clear_marks();
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            cycle();
            k++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        if (exp_q.size() > 0) flush();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (beat_cyc.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check_eq(tag, 64'(beat_cyc.size()), 64'(n));
    endtask

    task automatic check_gap(input string tag, input int a, input int b, input int gap);
        if (beat_cyc.size() > b) check_eq(tag, 64'(beat_cyc[b] - beat_cyc[a]), 64'(gap));
        else check_eq({tag, "_count"}, 64'(beat_cyc.size()), 64'(b + 1));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        tog = 1'b0;
        fired = '0;
        enable = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = '0;
        clear_marks();

        // Single requester 2, three beats, one-cycle arbitration latency.
        do_reset();
        load_pkt(2, 0, 3);
        drain("t1_drain", 20);
        if (beat_cyc.size() > 0) check_eq("t1_latency", 64'(beat_cyc[0] - first_req_cyc), 64'd1);
        check_gap("t1_span", 0, 2, 2);

        // All requesters busy: order 0,1,2,3,0 with one bubble per packet.
        do_reset();
        load_pkt(0, 0, 2);
        load_pkt(1, 0, 2);
        load_pkt(2, 0, 2);
        load_pkt(3, 0, 2);
        for (int i = 0; i < 2; i++) begin
            src_q[0].push_back(exp_q[i]);
            exp_q.push_back(exp_q[i]);
        end
        for (int i = 0; i < 2; i++) exp_q[8 + i].data[15:8] = 8'd1;
        src_q[0][2].data[15:8] = 8'd1;
        src_q[0][3].data[15:8] = 8'd1;
        drive();
        drain("t2_drain", 40);
        if (beat_cyc.size() > 0) check_eq("t2_latency", 64'(beat_cyc[0] - first_req_cyc), 64'd1);
        check_gap("t2_span", 0, 9, 13);

        // Backpressure toggling on a 4-beat packet from requester 1.
        do_reset();
        tog = 1'b1;
        load_pkt(1, 0, 4);
        drain("t3_drain", 30);
        tog = 1'b0;
        m_axis_tready = 1'b1;

        // Enable dropped mid-packet from requester 3; requester 0 waits.
        do_reset();
        load_pkt(3, 0, 5);
        wait_beats("t4_first_beat", 1, 10);
        enable = 1'b0;
        load_pkt(0, 0, 2);
        begin
            int k = 0;
            while (exp_q.size() > 2 && k < 20) begin
                cycle();
                k++;
            end
        end
        check_eq("t4_req3_done", 64'(exp_q.size()), 64'd2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t4_hold_idle", 64'(busy), 64'd0);
        end
        enable = 1'b1;
        cycle();
        check_eq("t4_regrant_busy", 64'(busy), 64'd1);
        check_eq("t4_regrant_dest", 64'(m_axis_tdest), 64'd0);
        drain("t4_drain", 10);

        // Reset on beat 2 of requester 1's packet.
        do_reset();
        load_pkt(1, 0, 4);
        wait_beats("t5_first_beat", 1, 10);
        areset = 1'b1;
        cycle();
        check_eq("t5_rst_sready", 64'(s_axis_tready), 64'd0);
        check_eq("t5_rst_busy", 64'(busy), 64'd0);
        flush();
        areset = 1'b0;
        clear_marks();
        for (int i = 0; i < NUM; i++) load_pkt(i, 1, 1);
        drain("t5_drain", 30);
        check_gap("t5_span", 0, 3, 6);

        // One-beat packet from 3, then wrap-around to 0 after one bubble.
        do_reset();
        load_pkt(3, 0, 1);
        begin
            int k = 0;
            while (!busy && k < 10) begin
                cycle();
                k++;
            end
        end
        check_eq("t6_granted", 64'(busy), 64'd1);
        load_pkt(0, 0, 1);
        drain("t6_drain", 10);
        check_gap("t6_wrap_gap", 0, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
